imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time controller for the instruction memory. Receives a byte stream (UART/debug
//  link), assembles little-endian 32-bit words, writes them to consecutive imem word
//  addresses, and owns the imem address port while loading. Holds the core (cpu_run=0)
//  until a complete image is in memory. Sits between the byte source, the core fetch
//  address and instrMem.
// PARAMETERS
//  IMEM_BITS  10  imem word-address width; capacity = 2**IMEM_BITS words (tracks `IMEM_BITS)
// PORTS
//  clk           in   1          system clock, all state on rising edge
//  reset         in   1          synchronous, active-high
//  start         in   1          1-cycle pulse: begin a new load
//  in_valid      in   1          byte source has a byte
//  in_data       in   8          byte value
//  in_ready      out  1          byte accepted when in_valid & in_ready
//  cpu_addr      in   32         core fetch address (word index)
//  imem_addr     out  32         address to instrMem
//  imem_we       out  1          1-cycle word write strobe
//  imem_wdata    out  32         word to write
//  cpu_run       out  1          core may fetch/execute
//  busy          out  1          load in progress (HDR/CHECK/DATA/WRITE)
//  error         out  1          last load rejected (image too large)
//  words_loaded  out  IMEM_BITS+1  words written by current/last load
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, imem_we=0, imem_wdata=0, cpu_run=0, busy=0, error=0,
//   words_loaded=0, byte counter=0. Reset mid-load aborts; words already written stay in imem.
//  Stream format: 4-byte header N (word count, LE), then N words, 4 bytes each, LE
//   (first byte -> bits[7:0]).
//  States:
//   IDLE  : in_ready=0. start -> HDR.
//   HDR   : in_ready=1; shift 4 bytes into N. 4th byte accepted -> CHECK.
//   CHECK : 1 cycle, in_ready=0. N==0 -> DONE; N > 2**IMEM_BITS -> ERR; else DATA.
//   DATA  : in_ready=1; shift bytes into word reg. 4th byte accepted -> WRITE.
//   WRITE : 1 cycle, in_ready=0, imem_we=1, imem_addr=words_loaded (zero-extended),
//           imem_wdata=assembled word; words_loaded+1 at end of cycle.
//           words_loaded+1==N -> DONE, else DATA.
//   DONE  : cpu_run=1, error=0. start -> HDR (cpu_run drops next cycle).
//   ERR   : cpu_run=0, error=1, no imem writes. start -> HDR (error clears on entry to HDR).
//  start while busy: ignored. start sets words_loaded=0 on entry to HDR.
//  Latency: 4th byte of word k accepted in cycle t -> imem_we in t+1 -> next byte
//   acceptable t+2. Last word: DONE/cpu_run=1 at t+2.
//  Address mux (combinational): imem_addr = state==WRITE ? words_loaded : cpu_addr.
//  imem_we is never asserted outside WRITE; imem_wdata holds last written word otherwise.
//  N == 2**IMEM_BITS is legal (fills memory exactly, no wrap); words_loaded saturates there.
//  in_valid with in_ready=0: byte not consumed; source must hold it.
//  Byte gaps (in_valid low) of any length are tolerated in HDR and DATA; no timeout.
// TESTING
//  1 reset, no start -> cpu_run=0, in_ready=0, imem_we never 1, imem_addr==cpu_addr.
//  2 start; bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> writes addr0=0x12345678,
//    addr1=0xDEADBEEF, each imem_we 1 cycle; cpu_run=1 two cycles after last byte;
//    words_loaded=2.
//  3 header N=0 -> DONE after CHECK, no imem_we, cpu_run=1.
//  4 IMEM_BITS=4, header N=17 -> error=1, cpu_run=0, no writes; start + N=16 full image
//    -> 16 writes addr0..15, error=0, cpu_run=1.
//  5 in_valid toggled randomly with gaps; start pulsed during DATA -> same words as case 2,
//    start ignored.
//  6 reset asserted after 1st word written -> next cycle IDLE, all outputs at reset values;
//    restart loads cleanly from addr0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory bus seen by the boot loader.
// The master modport is the loader's view; slave is the environment's
// view (byte source + instrMem).
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_addr, imem_we, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_addr, imem_we, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a 4-byte LE word count, then
// that many LE words, writes them to consecutive imem word addresses and
// releases the core once the whole image is in memory.
module imem_loader #(
    parameter int IMEM_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          cpu_addr,
    imem_loader_if.master        bus,
    output logic                 cpu_run,
    output logic                 busy,
    output logic                 error,
    output logic [IMEM_BITS:0]   words_loaded
);
    // Capacity held one bit wider than the header so N == 2**IMEM_BITS is
    // comparable without overflow.
    localparam logic [32:0] CAP = 33'(1) << IMEM_BITS;

    typedef enum logic [2:0] {IDLE, HDR, CHECK, DATA, WRITE, DONE, ERR} state_t;

    state_t             state_q;
    logic [1:0]         byte_cnt_q;
    logic [31:0]        n_q;
    logic [31:0]        word_q;
    logic [31:0]        wdata_q;
    logic               in_ready_q;
    logic               we_q;
    logic               cpu_run_q;
    logic               busy_q;
    logic               error_q;
    logic [IMEM_BITS:0] wl_q;

    logic               fire;
    logic [31:0]        n_d;
    logic [31:0]        word_d;
    logic [IMEM_BITS:0] wl_d;
    logic               last_word;

    // Byte handshake and shift-in of the next LE byte (first byte ends in [7:0]).
    always_comb begin
        fire      = bus.in_valid & in_ready_q;
        n_d       = {bus.in_data, n_q[31:8]};
        word_d    = {bus.in_data, word_q[31:8]};
        wl_d      = wl_q + 1'b1;
        last_word = (32'(wl_d) == n_q);
    end

    // Loader FSM; every output is registered and set on the transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            n_q        <= '0;
            word_q     <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            cpu_run_q  <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            wl_q       <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    // A new load is only honoured when not already loading.
                    if (start) begin
                        state_q    <= HDR;
                        byte_cnt_q <= '0;
                        in_ready_q <= 1'b1;
                        cpu_run_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        wl_q       <= '0;
                    end
                end
                HDR: begin
                    if (fire) begin
                        n_q        <= n_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q    <= CHECK;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    if (n_q == 32'd0) begin
                        state_q   <= DONE;
                        cpu_run_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if ({1'b0, n_q} > CAP) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (fire) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q    <= WRITE;
                            in_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                            wdata_q    <= word_d;
                        end
                    end
                end
                WRITE: begin
                    we_q <= 1'b0;
                    wl_q <= wl_d;
                    if (last_word) begin
                        state_q   <= DONE;
                        cpu_run_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q    <= DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The loader owns the imem address only for the single write cycle.
    assign bus.imem_addr  = (state_q == WRITE) ? 32'(wl_q) : cpu_addr;
    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_run        = cpu_run_q;
    assign busy           = busy_q;
    assign error          = error_q;
    assign words_loaded   = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (IMEM_BITS=4 so capacity limits are reachable).
module tb_imem_loader;
    localparam int IB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   cpu_addr = '0;
    logic          cpu_run, busy, error;
    logic [IB:0]   words_loaded;

    imem_loader_if bus();

    imem_loader #(.IMEM_BITS(IB)) dut (
        .clk(clk), .reset(reset), .start(start), .cpu_addr(cpu_addr),
        .bus(bus.master), .cpu_run(cpu_run), .busy(busy), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t         sb[$];
    logic [31:0] img[$];
    int          n_chk = 0;
    int          n_err = 0;
    bit          prev_we = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Core fetch address wanders randomly so the address mux is exercised.
    initial forever begin
        @(posedge clk);
        cpu_addr = $urandom;
    end

    // Write monitor: every strobe must match the next scoreboard entry,
    // be a single cycle, and outside writes imem_addr must follow cpu_addr.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            chk("we_expected", 32'(sb.size() != 0), 32'd1);
            chk("we_pulse", 32'(prev_we), 32'd0);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                chk("waddr", bus.imem_addr, e.a);
                chk("wdata", bus.imem_wdata, e.d);
            end
        end else begin
            chk("addr_mux", bus.imem_addr, cpu_addr);
        end
        prev_we = bus.imem_we;
    end

    // Called at a negedge; returns at the negedge just after the byte's accept edge.
    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int t;
        if (gappy) repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] n, input bit gappy);
        for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], gappy);
    endtask

    // Full load of img[0..nw-1] under header n; outcome: 0=done, 1=error.
    task automatic load(input logic [31:0] n, input int nw, input bit gappy,
                        input bit mid_start, input bit expect_err);
        pulse_start();
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_error_clr", 32'(error), 32'd0);
        chk("hdr_run_clr", 32'(cpu_run), 32'd0);
        chk("hdr_wl_clr", 32'(words_loaded), 32'd0);
        send_header(n, gappy);
        for (int i = 0; i < nw; i++) begin
            logic [31:0] w;
            w = img[i];
            sb.push_back('{a: 32'(i), d: w});
            for (int b = 0; b < 4; b++) begin
                if (mid_start && i == 1 && b == 1) begin
                    pulse_start();
                    chk("start_ignored_busy", 32'(busy), 32'd1);
                end
                send_byte(w[8*b +: 8], gappy);
            end
        end
        // Last byte accepted one edge ago: outcome becomes visible one edge later.
        chk("run_not_early", 32'(cpu_run), 32'd0);
        chk("err_not_early", 32'(error), 32'd0);
        @(negedge clk);
        chk("cpu_run", 32'(cpu_run), 32'(!expect_err));
        chk("error", 32'(error), 32'(expect_err));
        chk("busy_end", 32'(busy), 32'd0);
        chk("words_loaded", 32'(words_loaded), 32'(nw));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("outcome_hold", 32'(cpu_run), 32'(!expect_err));
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: idle after reset, source offering a byte that must not be taken.
        check_reset_vals();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (8) @(negedge clk);
        check_reset_vals();
        bus.in_valid = 1'b0;

        // 2: two-word image.
        img = '{32'h12345678, 32'hDEADBEEF};
        load(32'd2, 2, 1'b0, 1'b0, 1'b0);

        // 3: empty image.
        load(32'd0, 0, 1'b0, 1'b0, 1'b0);

        // 4: oversize rejected, then exactly-full image.
        load(32'd17, 0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("err_no_writes", 32'(sb.size()), 32'd0);
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back($urandom);
        load(32'd16, 16, 1'b0, 1'b0, 1'b0);

        // 5: gappy source and a stray start during DATA.
        img = '{32'h12345678, 32'hDEADBEEF};
        load(32'd2, 2, 1'b1, 1'b1, 1'b0);

        // 6: reset after the first write, then a clean restart from address 0.
        pulse_start();
        send_header(32'd2, 1'b0);
        sb.push_back('{a: 32'd0, d: img[0]});
        for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals();
        chk("rst_sb_drained", 32'(sb.size()), 32'd0);
        img = '{32'hCAFEF00D, 32'h0BADC0DE};
        load(32'd2, 2, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard stop if something wedges despite the per-byte bounds.
    initial begin
        #500000;
        $display("FAIL global_timeout: got %0t expected <500000", $time);
        $fatal(1, "timeout");
    end
endmodule
